alu_serial_ctrl: RTL and testbench

Bit-serial ALU sequencer for the Guia 05 ALU datapath. It reuses one 1-bit full-adder slice over WIDTH clock cycles, LSB first, to perform ADD/SUB/AND/OR on two WIDTH-bit operands. It then produces result, carry and zero flags, with the zero flag matching the equals-to-zero check on the full word. It sits between a requesting master (testbench or future CPU control) and the ALU datapath, and uses a start/busy/done handshake.

---
 rtl/alu_serial_ctrl.sv | 79 +++++++
 tb/tb_alu_serial_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ADD/SUB/AND/OR sequencer with start/busy/done handshake.
// Define ALU_OVF_EN to add the registered two's-complement overflow flag ovf.
module alu_serial_ctrl #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0] sa, sb, acc, acc_d;
    logic [CNT_W-1:0] cnt;
    logic [1:0] op_q;
    logic c, c_d, bit_s, last, load;
    // a start on the edge closing DONE is taken, so back-to-back ops issue every WIDTH+1 cycles
    always_comb begin
        bit_s = op_q[1] ? (op_q[0] ? sa[0] | sb[0] : sa[0] & sb[0]) : sa[0] ^ sb[0] ^ c;
        c_d = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
        acc_d = {bit_s, acc[WIDTH-1:1]};
        last = cnt == CNT_W'(WIDTH - 1);
        load = start && state != RUN;
        state_d = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
        busy = state == RUN;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa <= '0;
            sb <= '0;
            acc <= '0;
            cnt <= '0;
            op_q <= '0;
            c <= 1'b0;
            result <= '0;
            carry <= 1'b0;
            zero <= 1'b0;
`ifdef ALU_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            state <= state_d;
            if (load) begin
                sa <= a;
                sb <= op == 2'b01 ? ~b : b;
                c <= op == 2'b01;
                op_q <= op;
                cnt <= '0;
            end else if (state == RUN) begin
                sa <= sa >> 1;
                sb <= sb >> 1;
                acc <= acc_d;
                c <= c_d;
                cnt <= cnt + 1'b1;
                if (last) begin
                    result <= acc_d;
                    carry <= ~op_q[1] & c_d;
                    zero <= acc_d == '0;
`ifdef ALU_OVF_EN
                    ovf <= ~op_q[1] & (c ^ c_d);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: randomized and directed checks of alu_serial_ctrl against a word-level model.
module tb_alu_serial_ctrl;
    localparam int W = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [1:0] op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic busy, done, carry, zero;
    logic [W-1:0] result;
`ifdef ALU_OVF_EN
    logic ovf;
`endif
    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int last_done = -1;
    logic [W-1:0] exp_r = '0;
    logic exp_c = 1'b0;
    logic exp_z = 1'b0;
    logic exp_v = 1'b0;

    alu_serial_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result),
        .carry(carry),
`ifdef ALU_OVF_EN
        .ovf(ovf),
`endif
        .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // word-level reference: returns {ovf, zero, carry, result}
    function automatic logic [W+2:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int s;
        logic [W-1:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (o)
            2'd0: begin
                s = int'(x) + int'(y);
                r = s[W-1:0];
                c = s >= (1 << W);
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            2'd1: begin
                r = x - y;
                c = x >= y;
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            2'd2: r = x & y;
            default: r = x | y;
        endcase
        return {v, r == '0, c, r};
    endfunction

    task automatic check_flags(input string tag);
        check({tag, "_result"}, result, exp_r);
        check({tag, "_carry"}, carry, exp_c);
        check({tag, "_zero"}, zero, exp_z);
`ifdef ALU_OVF_EN
        check({tag, "_ovf"}, ovf, exp_v);
`endif
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
        logic [W+2:0] e;
        int n;
        e = model(o, x, y);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = hold;
        a = hold ? '1 : W'($urandom);
        b = hold ? '1 : W'($urandom);
        op = hold ? 2'd0 : 2'($urandom);
        check("accept_busy", busy, 1);
        check("accept_done", done, 0);
        n = 0;
        while (!done && n < 3 * W) begin
            check_flags("held");
            @(posedge clk);
            #1;
            n++;
            if (!done) check("run_busy", busy, 1);
        end
        start = 1'b0;
        check("latency", n, W);
        check("done_busy", busy, 0);
        if (last_done >= 0) check("spacing", cyc - last_done, W + 1);
        last_done = cyc;
        {exp_v, exp_z, exp_c, exp_r} = e;
        check_flags("op");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_flags("rst");
        @(negedge clk);
        rst = 1'b0;
        do_op(2'd0, 6'd25, 6'd17, 1'b0);
        check("tp_add_42", result, 42);
        do_op(2'd0, 6'd63, 6'd1, 1'b0);
        check("tp_wrap_carry", carry, 1);
        do_op(2'd0, 6'd31, 6'd1, 1'b0);
        do_op(2'd1, 6'd20, 6'd20, 1'b0);
        do_op(2'd1, 6'd5, 6'd9, 1'b0);
        check("tp_sub_60", result, 60);
        do_op(2'd2, 6'b101010, 6'b111111, 1'b0);
        do_op(2'd3, 6'b000001, 6'b000010, 1'b0);
        do_op(2'd0, 6'd1, 6'd1, 1'b1);
        check("tp_ignored_start", result, 2);
        do_op(2'd0, 6'd10, 6'd10, 1'b0);
        @(negedge clk);
        op = 2'd0;
        a = 6'd10;
        b = 6'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun_busy", busy, 0);
        check("midrun_done", done, 0);
        {exp_v, exp_z, exp_c, exp_r} = '0;
        check_flags("midrun_rst");
        last_done = -1;
        do_op(2'd0, 6'd10, 6'd10, 1'b0);
        check("tp_after_rst", result, 20);
        repeat (40) do_op(2'($urandom), W'($urandom), W'($urandom), 1'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
